// File: rtl/cxs_rx_512to256.sv
// -----------------------------------------------------------------------------
// cxs_rx_512to256
//
// Receive-side unpacker: accepts 512-bit link packets into a small FIFO and
// splits each entry into one or two 256-bit CXS flits, low half first. Flits
// are sent toward the local protocol engine only while credits are held and
// the CXS link is activated (RUN or DRAIN).
//
// Optional build macro: CXS_RX_PARITY_EN
//   Adds rx_pkt_par[1:0] (even parity per 256-bit half, checked on write) and
//   the sticky par_err output. Data is forwarded unchanged either way.
//
// Ports
//   cxs_clk, cxs_rst_n  clock, asynchronous active-low reset
//   link_en             1 = bring interface up, 0 = take it down
//   rx_pkt_*            link packet input (vld/data/cntl/hvld/last), rx_ready
//   cxs_valid/data/cntl/last   registered flit output, zero when not valid
//   cxs_activereq/ack   activation handshake
//   cxs_crdgnt/crdrtn   credit grant in / credit return out
//   cxs_deacthint       peer requests deactivation
//   link_err            sticky: activeack dropped while activereq high
// -----------------------------------------------------------------------------
module cxs_rx_512to256 #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CRD    = 15,
  parameter int CRD_W      = $clog2(MAX_CRD + 1)
) (
  input  logic         cxs_clk,
  input  logic         cxs_rst_n,
  input  logic         link_en,
  input  logic         rx_pkt_vld,
  input  logic [511:0] rx_pkt_data,
  input  logic [27:0]  rx_pkt_cntl,
  input  logic [1:0]   rx_pkt_hvld,
  input  logic         rx_pkt_last,
`ifdef CXS_RX_PARITY_EN
  input  logic [1:0]   rx_pkt_par,
  output logic         par_err,
`endif
  output logic         rx_ready,
  output logic         cxs_valid,
  output logic [255:0] cxs_data,
  output logic [13:0]  cxs_cntl,
  output logic         cxs_last,
  output logic         cxs_activereq,
  input  logic         cxs_activeack,
  input  logic         cxs_crdgnt,
  output logic         cxs_crdrtn,
  input  logic         cxs_deacthint,
  output logic         link_err
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    ACT   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DEACT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [511:0]     mem_data  [FIFO_DEPTH];
  logic [27:0]      mem_cntl  [FIFO_DEPTH];
  logic             mem_hi    [FIFO_DEPTH];
  logic             mem_last  [FIFO_DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             half_sel;
  logic [CRD_W-1:0] crd, crd_nxt;

  logic             fifo_empty, wr_en, err, issue, pop, rtn, gnt, rx_ready_nxt;
  logic [255:0]     head_data;
  logic [13:0]      head_cntl;

  // Credit update with saturation at MAX_CRD; a decrement is only requested
  // while credits are held, so no underflow guard is needed.
  function automatic logic [CRD_W-1:0] crd_update(input logic [CRD_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
    logic [CRD_W:0] s;
    s = {1'b0, c} + (CRD_W+1)'(inc) - (CRD_W+1)'(dec);
    if (s > (CRD_W+1)'(MAX_CRD)) s = (CRD_W+1)'(MAX_CRD);
    return s[CRD_W-1:0];
  endfunction

  assign fifo_empty = (count == '0);
  // Packets whose low half is invalid (2'b00, 2'b10) are consumed but dropped.
  assign wr_en      = rx_pkt_vld & rx_ready & rx_pkt_hvld[0];
  assign err        = ((state == RUN) || (state == DRAIN)) & ~cxs_activeack;
  assign issue      = ((state == RUN) || (state == DRAIN)) & ~fifo_empty &
                      (crd != '0) & ~err;
  assign pop        = issue & (half_sel | ~mem_hi[rd_ptr]);
  assign rtn        = (state == DEACT) & (crd != '0);
  assign gnt        = cxs_crdgnt & (state != STOP) & ~err;
  assign crd_nxt    = err ? '0 : crd_update(crd, gnt, issue | rtn);
  assign count_nxt  = err ? '0 : count + CNT_W'(wr_en) - CNT_W'(pop);
  assign head_data  = half_sel ? mem_data[rd_ptr][511:256] : mem_data[rd_ptr][255:0];
  assign head_cntl  = half_sel ? mem_cntl[rd_ptr][27:14]   : mem_cntl[rd_ptr][13:0];

  // activereq stays up in DEACT until the final return pulse has been seen.
  assign cxs_activereq = (state == ACT) || (state == RUN) || (state == DRAIN) ||
                         ((state == DEACT) && ((crd != '0) || cxs_crdrtn));

  always_comb begin
    state_nxt    = state;
    rx_ready_nxt = 1'b0;
    unique case (state)
      STOP:  if (link_en) state_nxt = ACT;
      ACT:   if (cxs_activeack) state_nxt = RUN;
      RUN: begin
        if (err)                               state_nxt = STOP;
        else if (!link_en || cxs_deacthint)    state_nxt = DRAIN;
      end
      DRAIN: begin
        if (err)                               state_nxt = STOP;
        else if (fifo_empty && !half_sel)      state_nxt = DEACT;
      end
      DEACT: begin
        // A late grant would leave a stranded credit, so wait it out too.
        if ((crd == '0) && !cxs_crdrtn && !cxs_crdgnt && !cxs_activeack)
          state_nxt = STOP;
      end
      default: state_nxt = STOP;
    endcase
    rx_ready_nxt = (state_nxt == RUN) && (count_nxt != CNT_W'(FIFO_DEPTH));
  end

  // Entry storage: contents are don't-care until written, so no reset.
  always_ff @(posedge cxs_clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= rx_pkt_data;
      mem_cntl[wr_ptr] <= rx_pkt_cntl;
      mem_hi[wr_ptr]   <= rx_pkt_hvld[1];
      mem_last[wr_ptr] <= rx_pkt_last;
    end
  end

  // Control, pointers, credits and registered flit outputs.
  always_ff @(posedge cxs_clk or negedge cxs_rst_n) begin
    if (!cxs_rst_n) begin
      state      <= STOP;
      crd        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      half_sel   <= 1'b0;
      rx_ready   <= 1'b0;
      cxs_valid  <= 1'b0;
      cxs_data   <= '0;
      cxs_cntl   <= '0;
      cxs_last   <= 1'b0;
      cxs_crdrtn <= 1'b0;
      link_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      crd        <= crd_nxt;
      count      <= count_nxt;
      if (err) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        half_sel <= 1'b0;
        link_err <= 1'b1;
      end else begin
        if (wr_en) wr_ptr   <= wr_ptr + AW'(1);
        if (pop)   rd_ptr   <= rd_ptr + AW'(1);
        if (issue) half_sel <= ~pop;
      end
      rx_ready   <= rx_ready_nxt;
      cxs_valid  <= issue;
      cxs_data   <= issue ? head_data : '0;
      cxs_cntl   <= issue ? head_cntl : '0;
      cxs_last   <= pop & mem_last[rd_ptr];
      cxs_crdrtn <= rtn;
    end
  end

`ifdef CXS_RX_PARITY_EN
  logic par_bad;
  assign par_bad = (^rx_pkt_data[255:0] != rx_pkt_par[0]) |
                   (rx_pkt_hvld[1] & (^rx_pkt_data[511:256] != rx_pkt_par[1]));

  always_ff @(posedge cxs_clk or negedge cxs_rst_n) begin
    if (!cxs_rst_n)            par_err <= 1'b0;
    else if (wr_en && par_bad) par_err <= 1'b1;
  end
`endif

endmodule
